// File: rtl/aes_ctr_mode_ctrl.sv
// aes_ctr_mode_ctrl
//   CTR-mode wrapper around a single-issue AES-256 core. Holds the 128-bit counter
//   block {nonce, ctr}, issues it to the core with a start pulse, captures the
//   returned keystream and XORs it with one user block per valid/ready handshake.
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   init, iv_i            load a new counter block (clears ctr_wrap)
//   core_start/core_block request to the AES core (block = current counter)
//   core_done/core_ks     keystream return from the AES core
//   din_valid/din/din_ready     user input block handshake
//   dout_valid/dout/dout_ready  transformed output block handshake
//   ctr_wrap              sticky: counter field wrapped, stage halted until init
//   busy                  high in every state except IDLE and HALT
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no counter loaded, waiting for init
// ISSUE   | core_start pulse with core_block = counter
// WAIT_KS | core running; waiting for core_done
// READY   | keystream held, din_ready = 1
// OUT     | dout_valid held until dout_ready
// HALT    | counter wrapped; only init or rst leaves
module aes_ctr_mode_ctrl #(
  parameter int CTR_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic [127:0] iv_i,
  output logic         core_start,
  output logic [127:0] core_block,
  input  logic         core_done,
  input  logic [127:0] core_ks,
  input  logic         din_valid,
  input  logic [127:0] din,
  output logic         din_ready,
  output logic         dout_valid,
  output logic [127:0] dout,
  input  logic         dout_ready,
  output logic         ctr_wrap,
  output logic         busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT_KS = 3'd2;
  localparam logic [2:0] S_READY   = 3'd3;
  localparam logic [2:0] S_OUT     = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;

  logic [2:0]   state_q, state_d;
  logic [127:0] ctr_q, ctr_d;
  logic [127:0] ks_q, ks_d;
  logic [127:0] dout_q, dout_d;
  logic         dout_valid_q, dout_valid_d;
  logic         ctr_wrap_q, ctr_wrap_d;
  logic         pend_init_q, pend_init_d;
  logic [127:0] pend_iv_q, pend_iv_d;
  logic [127:0] ctr_inc;

  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    ks_d         = ks_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    ctr_wrap_d   = ctr_wrap_q;
    pend_init_d  = pend_init_q;
    pend_iv_d    = pend_iv_q;

    // only the counter field increments; nonce bits pass through untouched
    ctr_inc = ctr_q;
    ctr_inc[CTR_W-1:0] = ctr_q[CTR_W-1:0] + CTR_W'(1);

    case (state_q)
      S_IDLE: begin
        if (init) begin
          ctr_d      = iv_i;
          ctr_wrap_d = 1'b0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_KS;
        // core has been started and cannot abort; remember the new iv
        if (init) begin
          pend_init_d = 1'b1;
          pend_iv_d   = iv_i;
        end
      end
      S_WAIT_KS: begin
        if (core_done) begin
          if (init || pend_init_q) begin
            // keystream belongs to a stale counter: drop it and restart
            ctr_d       = init ? iv_i : pend_iv_q;
            ctr_wrap_d  = 1'b0;
            pend_init_d = 1'b0;
            state_d     = S_ISSUE;
          end else begin
            ks_d    = core_ks;
            ctr_d   = ctr_inc;
            if (&ctr_q[CTR_W-1:0]) ctr_wrap_d = 1'b1;
            state_d = S_READY;
          end
        end else if (init) begin
          pend_init_d = 1'b1;
          pend_iv_d   = iv_i;
        end
      end
      S_READY, S_OUT, S_HALT: begin
        if (init) begin
          ctr_d        = iv_i;
          ctr_wrap_d   = 1'b0;
          dout_valid_d = 1'b0;
          state_d      = S_ISSUE;
        end else if (state_q == S_READY && din_valid) begin
          dout_d       = din ^ ks_q;
          dout_valid_d = 1'b1;
          state_d      = S_OUT;
        end else if (state_q == S_OUT && dout_ready) begin
          dout_valid_d = 1'b0;
          state_d      = ctr_wrap_q ? S_HALT : S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ctr_q        <= '0;
      ks_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ctr_wrap_q   <= 1'b0;
      pend_init_q  <= 1'b0;
      pend_iv_q    <= '0;
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      ks_q         <= ks_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ctr_wrap_q   <= ctr_wrap_d;
      pend_init_q  <= pend_init_d;
      pend_iv_q    <= pend_iv_d;
    end
  end

  assign core_start = (state_q == S_ISSUE);
  assign core_block = ctr_q;
  assign din_ready  = (state_q == S_READY);
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign ctr_wrap   = ctr_wrap_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule

// File: tb/tb_aes_ctr_mode_ctrl.sv
module tb_aes_ctr_mode_ctrl;

  logic         clk = 1'b0;
  logic         rst, init;
  logic [127:0] iv_i;
  logic         core_start;
  logic [127:0] core_block;
  logic         core_done;
  logic [127:0] core_ks;
  logic         din_valid;
  logic [127:0] din;
  logic         din_ready;
  logic         dout_valid;
  logic [127:0] dout;
  logic         dout_ready;
  logic         ctr_wrap;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aes_ctr_mode_ctrl #(.CTR_W(32)) dut (
    .clk(clk), .rst(rst), .init(init), .iv_i(iv_i),
    .core_start(core_start), .core_block(core_block),
    .core_done(core_done), .core_ks(core_ks),
    .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .dout_valid(dout_valid), .dout(dout), .dout_ready(dout_ready),
    .ctr_wrap(ctr_wrap), .busy(busy)
  );

  localparam logic [127:0] NIST_IV = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  logic [127:0] nist_pt [4] = '{
    128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
    128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
  logic [127:0] nist_ct [4] = '{
    128'h601ec313775789a5b7a7f504bbf3d228, 128'hf443e3ca4d62b59aca84e990cacaf5c5,
    128'h2b0930daa23de94ce87017ba2d84988d, 128'hdfc9c58db67aada613c2dd08457941a6};

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stand-in for the AES core: the NIST counter blocks map to their true keystream
  // (pt ^ ct), every other block to an arbitrary but fixed scrambling.
  function automatic logic [127:0] ks_fn(input logic [127:0] b);
    logic [127:0] r;
    r = {b[95:0], b[127:96]} ^ {4{b[31:0] * 32'h9e3779b1}} ^ 128'h0123456789abcdeffedcba9876543210;
    for (int i = 0; i < 4; i++)
      if (b == NIST_IV + 128'(i)) r = nist_pt[i] ^ nist_ct[i];
    return r;
  endfunction

  int           core_cnt  = 0;
  int           fixed_lat = 0;
  int           n_start   = 0;
  logic [127:0] core_blk  = '0;

  initial begin
    core_done = 1'b0;
    core_ks   = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (rst) core_cnt = 0;
      else begin
        if (core_cnt > 0) begin
          chk("core_block_stable", core_block, core_blk);
          core_cnt--;
          if (core_cnt == 0) begin
            core_done = 1'b1;
            core_ks   = ks_fn(core_blk);
          end
        end
        if (core_start) begin
          core_blk = core_block;
          n_start++;
          core_cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
        end
      end
    end
  end

  // reference model: counter block that the next delivered block must use
  logic [127:0] m_ctr = '0;
  logic         m_wrap = 1'b0;
  int           m_blocks = 0;
  int           start_base = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_init(input logic [127:0] iv);
    start_base = n_start;
    init = 1'b1;
    iv_i = iv;
    tick();
    init     = 1'b0;
    m_ctr    = iv;
    m_wrap   = 1'b0;
    m_blocks = 0;
  endtask

  // mode 0: normal release, 1: init while dout pending, 2: rst while dout pending
  task automatic xfer(input logic [127:0] d, input int stall, input int mode,
                      input logic [127:0] new_iv, output logic [127:0] got);
    logic [127:0] exp_dout;
    logic         wrap_now;
    int           n;
    got      = '0;
    exp_dout = d ^ ks_fn(m_ctr);
    wrap_now = &m_ctr[31:0];
    din_valid = 1'b1;
    din       = d;
    n = 0;
    while (!din_ready && n < 200) begin
      tick();
      n++;
    end
    if (!din_ready) begin
      chk("din_ready_timeout", 128'(din_ready), 128'(1'b1));
      din_valid = 1'b0;
      return;
    end
    tick();
    din_valid = 1'b0;
    m_ctr[31:0] = m_ctr[31:0] + 32'd1;
    m_wrap = m_wrap | wrap_now;
    m_blocks++;
    got = dout;
    chk("dout_valid", 128'(dout_valid), 128'(1'b1));
    chk("dout", dout, exp_dout);
    chk("ctr_wrap", 128'(ctr_wrap), 128'(m_wrap));
    chk("starts_per_block", 128'(n_start - start_base), 128'(m_blocks));
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_dout", dout, exp_dout);
      chk("stall_ctl", 128'({din_ready, core_start, dout_valid}), 128'(3'b001));
    end
    if (mode == 0) begin
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      chk("release_valid", 128'(dout_valid), '0);
      if (m_wrap) chk("halted", 128'({busy, ctr_wrap}), 128'(2'b01));
      else        chk("reissue", 128'(core_start), 128'(1'b1));
    end else if (mode == 1) begin
      dout_ready = 1'b1;
      pulse_init(new_iv);
      dout_ready = 1'b0;
      chk("abort_ctl", 128'({dout_valid, core_start, ctr_wrap}), 128'(3'b010));
      chk("abort_block", core_block, new_iv);
    end else begin
      rst = 1'b1;
      dout_ready = 1'b1;
      tick();
      chk("rst_ctl", 128'({core_start, din_ready, dout_valid, ctr_wrap, busy}), '0);
      chk("rst_dout", dout, '0);
      rst = 1'b0;
      dout_ready = 1'b0;
      m_ctr = '0;
      m_wrap = 1'b0;
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("rst_idle", 128'({core_start, busy}), '0);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] got;
    logic [127:0] iv;
    rst = 1'b1; init = 1'b0; iv_i = '0; din_valid = 1'b0; din = '0; dout_ready = 1'b0;
    repeat (3) tick();
    chk("reset_ctl", 128'({core_start, din_ready, dout_valid, ctr_wrap, busy}), '0);
    chk("reset_dout", dout, '0);
    chk("reset_block", core_block, '0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_no_start", 128'({core_start, busy}), '0);

    // NIST SP800-38A F.5.5 vectors, second block with a long consumer stall
    pulse_init(NIST_IV);
    chk("init_block", core_block, NIST_IV);
    for (int i = 0; i < 4; i++) begin
      xfer(nist_pt[i], (i == 1) ? 20 : 0, 0, '0, got);
      chk("nist_ct", got, nist_ct[i]);
    end

    // wrap: the all-ones counter block is delivered, then the stage halts
    pulse_init({96'hdeadbeef_00112233_44556677, 32'hffffffff});
    xfer({$urandom, $urandom, $urandom, $urandom}, 2, 0, '0, got);
    din_valid = 1'b1;
    din = '1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_hold", 128'({din_ready, core_start, dout_valid, busy, ctr_wrap}), 128'(5'b00001));
    end
    pulse_init({96'hdeadbeef_00112233_44556677, 32'h00000005});
    chk("init_clears_wrap", 128'(ctr_wrap), '0);
    xfer({$urandom, $urandom, $urandom, $urandom}, 1, 0, '0, got);

    // init while the core is running: in-flight keystream dropped, last iv wins
    fixed_lat = 5;
    pulse_init(128'h11111111_22222222_33333333_44444444);
    tick();
    pulse_init(128'haaaaaaaa_bbbbbbbb_cccccccc_00000010);
    pulse_init(128'h99999999_88888888_77777777_00000020);
    begin
      int n;
      n = 0;
      while (!core_start && n < 50) begin
        chk("pend_no_dout", 128'(dout_valid), '0);
        tick();
        n++;
      end
    end
    chk("pend_block", core_block, 128'h99999999_88888888_77777777_00000020);
    xfer(128'h0f0e0d0c_0b0a0908_07060504_03020100, 0, 0, '0, got);
    fixed_lat = 0;

    // init in OUT together with dout_ready, then rst in OUT
    xfer(128'h5555, 3, 1, 128'h12345678_9abcdef0_0fedcba9_fffffffe, got);
    xfer(128'h6666, 0, 0, '0, got);
    xfer(128'h7777, 2, 2, '0, got);

    // randomized epochs; some start near the wrap point
    for (int e = 0; e < 6; e++) begin
      iv = {$urandom, $urandom, $urandom, $urandom};
      if (e % 2 == 1) iv[31:0] = 32'hfffffffd - 32'($urandom_range(0, 2));
      pulse_init(iv);
      for (int b = 0; b < 6 && !m_wrap; b++)
        xfer({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 3)), 0, '0, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
